// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// mem_bus_pkg
// Shared encodings and default widths for the I/D memory bus arbiter.
// Revision: 1.0
// ============================================================================
package mem_bus_pkg;

  localparam int ADDR_W_DEFAULT = 28;
  localparam int LINE_W_DEFAULT = 128;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_GNT_I = 2'd1;
  localparam logic [1:0] ST_GNT_D = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  typedef enum logic [1:0] {
    IDLE  = ST_IDLE,
    GNT_I = ST_GNT_I,
    GNT_D = ST_GNT_D,
    DONE  = ST_DONE
  } arb_state_t;

  // Encoding of the most recently granted requester
  localparam logic GRANT_I = 1'b0;
  localparam logic GRANT_D = 1'b1;

endpackage
`default_nettype wire

// File: rtl/rr_pick2.sv
`default_nettype none
// ============================================================================
// rr_pick2
// Two-way round-robin picker: on a tie the side not granted last time wins.
// Revision: 1.0
// ============================================================================
module rr_pick2
  import mem_bus_pkg::*;
(
  input  logic req_i,
  input  logic req_d,
  input  logic last_gnt,
  output logic gnt_i,
  output logic gnt_d
);

  always_comb begin
    gnt_i = req_i & (~req_d | (last_gnt == GRANT_D));
    gnt_d = req_d & (~req_i | (last_gnt == GRANT_I));
  end

endmodule
`default_nettype wire

// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// mem_bus_arbiter
// Round-robin sharing of the single memory port between I- and D-cache refill.
// Revision: 1.0
// ============================================================================
module mem_bus_arbiter
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = ADDR_W_DEFAULT,
  parameter int LINE_W = LINE_W_DEFAULT
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_mem_read,
  input  logic [ADDR_W-1:0] i_mem_addr,
  output logic [LINE_W-1:0] i_mem_rdata,
  output logic              i_mem_ready,
  input  logic              d_mem_read,
  input  logic              d_mem_write,
  input  logic [ADDR_W-1:0] d_mem_addr,
  input  logic [LINE_W-1:0] d_mem_wdata,
  output logic [LINE_W-1:0] d_mem_rdata,
  output logic              d_mem_ready,
  output logic              mem_read,
  output logic              mem_write,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [LINE_W-1:0] mem_wdata,
  input  logic [LINE_W-1:0] mem_rdata,
  input  logic              mem_ready
);

  arb_state_t        state, state_next;
  logic              last_gnt, last_gnt_next;
  logic              mem_read_next, mem_write_next;
  logic [ADDR_W-1:0] mem_addr_next;
  logic [LINE_W-1:0] mem_wdata_next;
  logic [LINE_W-1:0] i_rdata_next, d_rdata_next;
  logic              i_ready_next, d_ready_next;
  logic              req_i, req_d, gnt_i, gnt_d;

  assign req_i = i_mem_read;
  assign req_d = d_mem_read | d_mem_write;

  rr_pick2 u_pick (
    .req_i    (req_i),
    .req_d    (req_d),
    .last_gnt (last_gnt),
    .gnt_i    (gnt_i),
    .gnt_d    (gnt_d)
  );

  always_comb begin
    state_next     = state;
    last_gnt_next  = last_gnt;
    mem_read_next  = mem_read;
    mem_write_next = mem_write;
    mem_addr_next  = mem_addr;
    mem_wdata_next = mem_wdata;
    i_rdata_next   = i_mem_rdata;
    d_rdata_next   = d_mem_rdata;
    i_ready_next   = 1'b0;
    d_ready_next   = 1'b0;
    case (state)
      IDLE: begin
        if (gnt_d) begin
          // A write-back takes precedence over a simultaneous D-side read
          state_next     = GNT_D;
          last_gnt_next  = GRANT_D;
          mem_write_next = d_mem_write;
          mem_read_next  = ~d_mem_write;
          mem_addr_next  = d_mem_addr;
          mem_wdata_next = d_mem_wdata;
        end else if (gnt_i) begin
          state_next     = GNT_I;
          last_gnt_next  = GRANT_I;
          mem_read_next  = 1'b1;
          mem_write_next = 1'b0;
          mem_addr_next  = i_mem_addr;
        end
      end
      GNT_I: begin
        if (mem_ready) begin
          i_rdata_next   = mem_rdata;
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          i_ready_next   = 1'b1;
          state_next     = DONE;
        end
      end
      GNT_D: begin
        if (mem_ready) begin
          d_rdata_next   = mem_rdata;
          mem_read_next  = 1'b0;
          mem_write_next = 1'b0;
          d_ready_next   = 1'b1;
          state_next     = DONE;
        end
      end
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= IDLE;
      last_gnt    <= GRANT_I;
      mem_read    <= 1'b0;
      mem_write   <= 1'b0;
      mem_addr    <= '0;
      mem_wdata   <= '0;
      i_mem_rdata <= '0;
      d_mem_rdata <= '0;
      i_mem_ready <= 1'b0;
      d_mem_ready <= 1'b0;
    end else begin
      state       <= state_next;
      last_gnt    <= last_gnt_next;
      mem_read    <= mem_read_next;
      mem_write   <= mem_write_next;
      mem_addr    <= mem_addr_next;
      mem_wdata   <= mem_wdata_next;
      i_mem_rdata <= i_rdata_next;
      d_mem_rdata <= d_rdata_next;
      i_mem_ready <= i_ready_next;
      d_mem_ready <= d_ready_next;
    end
  end

endmodule
`default_nettype wire

// File: doc/mem_bus_arbiter.md
# mem_bus_arbiter

Shares the single off-chip memory port between the instruction-cache and data-cache refill/write-back paths. The fetch stage's I-cache and the MEM stage's D-cache each present a blocking line request. The arbiter grants one requester at a time with round-robin fairness, drives the registered memory interface, and returns the line and a one-cycle ready pulse to the winner. It sits between the two cache controllers and the top-level memory pins.

## Interface
- ADDR_W, 28: line address width (byte address [31:4]).
- LINE_W, 128: cache line width in bits.
- clk  in  1  clock.
- rst_n  in  1  reset, synchronous, active-low.
- i_mem_read  in  1  I-cache line-read request; held until i_mem_ready.
- i_mem_addr  in  ADDR_W  I-cache line address.
- i_mem_rdata  out  LINE_W  line returned to I-cache; valid when i_mem_ready.
- i_mem_ready  out  1  one-cycle completion pulse to I-cache.
- d_mem_read  in  1  D-cache line-read request; held until d_mem_ready.
- d_mem_write  in  1  D-cache write-back request; held until d_mem_ready.
- d_mem_addr  in  ADDR_W  D-cache line address.
- d_mem_wdata  in  LINE_W  write-back data.
- d_mem_rdata  out  LINE_W  line returned to D-cache; valid when d_mem_ready.
- d_mem_ready  out  1  one-cycle completion pulse to D-cache.
- mem_read  out  1  registered read strobe to memory.
- mem_write  out  1  registered write strobe to memory.
- mem_addr  out  ADDR_W  registered address to memory.
- mem_wdata  out  LINE_W  registered write data to memory.
- mem_rdata  in  LINE_W  memory read data; valid when mem_ready.
- mem_ready  in  1  memory completion; may arrive any cycle ≥1 after the strobe.

## Operation
- FSM states: IDLE, GNT_I, GNT_D, DONE.
- IDLE:
  - No request: stay in IDLE.
  - One requester active: grant it.
  - Both active: grant the requester opposite to `last_gnt`.
  - On grant, update `last_gnt`; load mem_addr, mem_wdata, and the strobes for the next cycle.
- D-side request is d_mem_read | d_mem_write. If both are high, treat it as a write; the read is not issued.
- GNT_I / GNT_D:
  - Hold the memory strobes, address and data constant.
  - On mem_ready, capture mem_rdata into the granted side's rdata register, clear the strobes, assert the granted ready, and go to DONE.
- DONE: ready pulses for exactly this cycle; then go to IDLE. The cache has deasserted its request by the IDLE cycle.
- Transactions are never aborted. A pipeline flush or stall while a request is outstanding does not affect the arbiter.
- A D-cache write-back followed by a refill is two transactions. The I-cache may be granted between them.
- The non-granted rdata output holds its last captured value.
- Reset values:
  - All strobes and both ready outputs: 0.
  - All rdata, mem_addr, mem_wdata: 0.
  - State: IDLE.
  - `last_gnt` = I, so the D-cache wins the first tie.

## Timing
- Requests are sampled in IDLE at cycle N.
- Memory strobes are high from N+1.
- If mem_ready arrives at cycle K ≥ N+1:
  - Strobes are low and the requester's ready is high at K+1 (DONE).
  - IDLE is reached at K+2.
- Minimum request-to-ready latency is 2 cycles; back-to-back grants are separated by one IDLE cycle.
- mem_ready outside GNT_I/GNT_D is ignored.
- Reset asserted mid-transaction forces IDLE and clears strobes in the next cycle. No ready is issued for the killed transaction.
- All outputs are registered; there are no combinational paths from inputs to outputs.

## Structure
- Shared package `mem_bus_pkg`:
  - State encoding localparams (IDLE/GNT_I/GNT_D/DONE).
  - ADDR_W/LINE_W defaults.
  - GRANT_I/GRANT_D encoding for `last_gnt`.
- Sub-module `rr_pick2`: combinational two-way round-robin picker (req_i, req_d, last_gnt → gnt_i, gnt_d). It is used only in IDLE.
- The remainder is the FSM and the output registers in the top module, about 150–200 lines in total.

## Test plan
- Reset, then I-only read of addr 0x0000010 with memory returning 0xA5…A5 after 3 cycles:
  - mem_read is high for 3 cycles from N+1.
  - i_mem_ready pulses once at K+1 with rdata 0xA5…A5.
  - d_mem_ready stays 0.
- Simultaneous I read and D read right after reset:
  - D is granted first; I is granted after D's DONE plus one IDLE cycle.
  - On the next simultaneous pair, I wins.
- D write-back (addr 0x0000020, wdata 0x1234…) with d_mem_read also high:
  - Only mem_write is issued, with the correct addr and wdata.
  - d_mem_ready pulses once.
- Continuous I requests with a D request arriving mid-transaction: D is granted immediately after the current I transaction, proving no starvation.
- Reset asserted 2 cycles into a GNT_D wait:
  - Strobes are 0 the next cycle and no ready pulse is issued.
  - A post-reset I request completes normally.
- mem_ready pulsed while in IDLE: no state change and no ready output.
